cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL use one clock and a synchronous, active-high reset; ports clk, rst, rdy as below.
REQ-002 clk  input  1  system clock; all state updates on posedge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 rdy  input  1  global enable; low = pause.
REQ-005 valid_from_alu / rob_id_from_alu / result_from_alu  input  1 / ROB_ID / 32  ALU (RS) result request.
REQ-006 valid_from_lsb / rob_id_from_lsb / result_from_lsb  input  1 / ROB_ID / 32  LSB result request.
REQ-007 ready_to_alu, ready_to_lsb  output  1  per-source accept (FIFO not full and rdy high).
REQ-008 commit_jump_flag_from_rob  input  1  misprediction flush.
REQ-009 cdb_valid / cdb_rob_id / cdb_result  output  1 / ROB_ID / 32  registered broadcast to ROB, RS, LSB, dispatcher.
REQ-010 cdb_src  output  1  0 = ALU, 1 = LSB; source of the current broadcast.

Function
REQ-011 SHALL hold one FIFO per source, depth CDB_FIFO_DEPTH (default 2), with wrap-around read/write pointers and a count.
REQ-012 SHALL push on a posedge when valid_from_x && ready_to_x && rob_id_from_x != ZERO_ROB; a request with rob_id ZERO_ROB is dropped, with no push.
REQ-013 ready_to_x SHALL be derived from the registered count only (count < DEPTH) && rdy, with no same-cycle pop credit; valid while ready is low is ignored and the source holds.
REQ-014 SHALL pop at most one FIFO head per cycle and register it onto the cdb_* outputs at the same posedge.
REQ-015 Latency: a request accepted at edge T appears with cdb_valid=1 after edge T+1 if uncontended; the empty-FIFO bypass path is not provided.
REQ-016 Arbitration with one FIFO non-empty: grant it. With both non-empty: see REQ-024/025. With both empty: cdb_valid<=0 next edge.
REQ-017 cdb_valid SHALL be a single-cycle pulse per popped entry; back-to-back broadcasts are allowed every cycle.
REQ-018 A simultaneous push and pop on the same FIFO SHALL keep the count unchanged and preserve FIFO order.
REQ-019 commit_jump_flag_from_rob high at an edge SHALL clear both FIFOs (pointers and counts to 0) and set cdb_valid<=0; same-edge pushes are discarded; it takes priority over rdy.
REQ-020 rdy low SHALL block push and pop, hold FIFO state, drive cdb_valid<=0, and hold cdb_rob_id, cdb_result and cdb_src.

Reset
REQ-021 On rst at posedge, all FIFO pointers and counts SHALL go to 0, cdb_valid to 0, cdb_rob_id to ZERO_ROB, cdb_result to 0, cdb_src to 0, and the RR pointer to 0 (ALU preferred next).
REQ-022 rst SHALL override flush and rdy; ready_to_* SHALL be low during the reset cycle.
REQ-023 Reset mid-operation SHALL lose all pending entries, with no partial broadcast.

Configuration
REQ-024 With CDB_RR_EN defined: when both FIFOs are non-empty, grant the source not granted last, and update the 1-bit RR pointer only on a contended grant.
REQ-025 Without CDB_RR_EN: fixed priority, where LSB beats ALU, and the RR pointer logic is absent.

Structure
REQ-026 ROB_ID_TYPE, DATA_TYPE, ZERO_ROB, CDB_FIFO_DEPTH and the CDB_SRC_ALU/CDB_SRC_LSB encodings SHALL live in the shared defines file.
REQ-027 SHALL instantiate a sub-module cdb_fifo (push, pop, flush, data, count, full, empty) twice, with the arbiter and output register in cdb_arbiter.

Verification
REQ-028 Single ALU push (rob_id=3, result=0x11) at edge 0 -> cdb_valid=1, rob_id=3, result=0x11, src=0 after edge 1, and cdb_valid=0 after edge 2.
REQ-029 ALU (5, 0xA) and LSB (6, 0xB) pushed at the same edge: with CDB_RR_EN, broadcast order is 5 then 6 on consecutive cycles; without it, the order is 6 then 5.
REQ-030 Three ALU pushes on consecutive cycles with LSB saturated and fixed priority -> ready_to_alu drops after 2 accepted; the third is held and accepted once the count is below 2; all three rob_ids are broadcast in order.
REQ-031 Both FIFOs hold 2 entries, and commit_jump_flag_from_rob pulses with a same-edge ALU push -> no cdb_valid afterwards, both counts 0, ready_to_* high next cycle.
REQ-032 Push with rob_id=ZERO_ROB -> no broadcast, count unchanged; rdy low for 3 cycles with 1 entry pending -> no cdb_valid until rdy returns, then the entry is broadcast after 1 edge.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared types and constants for the common data bus arbiter.
// Holds the ROB id / data types, FIFO depth and source encodings.
package cdb_arbiter_pkg;

  localparam int ROB_ID_W       = 4;
  localparam int DATA_W         = 32;
  localparam int CDB_FIFO_DEPTH = 2;

  // ROB_ID_TYPE / DATA_TYPE
  typedef logic [ROB_ID_W-1:0] rob_id_t;
  typedef logic [DATA_W-1:0]   data_t;

  // ROB id 0 is reserved as "no instruction"; requests carrying it are dropped.
  localparam rob_id_t ZERO_ROB = '0;

  typedef enum logic {
    CDB_SRC_ALU = 1'b0,
    CDB_SRC_LSB = 1'b1
  } cdb_src_e;

  typedef struct packed {
    rob_id_t rob_id;
    data_t   result;
  } cdb_entry_t;

  localparam int CNT_W = $clog2(CDB_FIFO_DEPTH + 1);
  localparam int PTR_W = (CDB_FIFO_DEPTH > 1) ? $clog2(CDB_FIFO_DEPTH) : 1;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(CDB_FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Bundle of result requests, flush and broadcast signals of the CDB arbiter.
// Handshake: a source entry transfers on a posedge where valid_from_x && ready_to_x;
// the source keeps valid and its payload stable while ready_to_x is low.
interface cdb_arbiter_if
  import cdb_arbiter_pkg::*;
();

  logic       valid_from_alu;
  rob_id_t    rob_id_from_alu;
  data_t      result_from_alu;
  logic       ready_to_alu;

  logic       valid_from_lsb;
  rob_id_t    rob_id_from_lsb;
  data_t      result_from_lsb;
  logic       ready_to_lsb;

  logic       commit_jump_flag_from_rob;

  logic       cdb_valid;
  rob_id_t    cdb_rob_id;
  data_t      cdb_result;
  cdb_src_e   cdb_src;

  // Occupancy of each source FIFO, exposed for observation.
  logic [CNT_W-1:0] alu_count;
  logic [CNT_W-1:0] lsb_count;

  modport master (
    output valid_from_alu, rob_id_from_alu, result_from_alu,
    output valid_from_lsb, rob_id_from_lsb, result_from_lsb,
    output commit_jump_flag_from_rob,
    input  ready_to_alu, ready_to_lsb,
    input  cdb_valid, cdb_rob_id, cdb_result, cdb_src,
    input  alu_count, lsb_count
  );

  modport slave (
    input  valid_from_alu, rob_id_from_alu, result_from_alu,
    input  valid_from_lsb, rob_id_from_lsb, result_from_lsb,
    input  commit_jump_flag_from_rob,
    output ready_to_alu, ready_to_lsb,
    output cdb_valid, cdb_rob_id, cdb_result, cdb_src,
    output alu_count, lsb_count
  );

endinterface

// File: rtl/cdb_fifo.sv
// Per-source result FIFO with wrap-around pointers and an occupancy count.
// flush and rst clear pointers and count; a push on a flush edge is discarded.
module cdb_fifo
  import cdb_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  cdb_entry_t       data,
  input  logic             pop,
  output cdb_entry_t       head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  cdb_entry_t       mem_q [CDB_FIFO_DEPTH];
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(CDB_FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      // Push and pop together leave the count unchanged.
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_push) mem_q[wr_ptr_q] <= data;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: buffers ALU and LSB results and broadcasts one per cycle.
// Define CDB_RR_EN for round-robin between contending sources; default is LSB-first.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
(
  input logic          clk,
  input logic          rst,
  input logic          rdy,
  cdb_arbiter_if.slave bus
);

  logic       flush;
  logic       alu_push, lsb_push, alu_pop, lsb_pop;
  logic       alu_full, lsb_full, alu_empty, lsb_empty;
  cdb_entry_t alu_head, lsb_head;
  logic       grant_en, contended;
  cdb_src_e   grant_src;

  logic     cdb_valid_q, cdb_valid_d;
  rob_id_t  cdb_rob_id_q, cdb_rob_id_d;
  data_t    cdb_result_q, cdb_result_d;
  cdb_src_e cdb_src_q, cdb_src_d;

  assign flush = bus.commit_jump_flag_from_rob;

  // Ready depends on registered occupancy only; a pop in the same cycle gives no credit.
  assign bus.ready_to_alu = !rst && rdy && !alu_full;
  assign bus.ready_to_lsb = !rst && rdy && !lsb_full;

  assign alu_push = bus.valid_from_alu && bus.ready_to_alu && (bus.rob_id_from_alu != ZERO_ROB);
  assign lsb_push = bus.valid_from_lsb && bus.ready_to_lsb && (bus.rob_id_from_lsb != ZERO_ROB);

  cdb_fifo u_alu_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (alu_push),
    .data  ('{rob_id: bus.rob_id_from_alu, result: bus.result_from_alu}),
    .pop   (alu_pop),
    .head  (alu_head),
    .count (bus.alu_count),
    .full  (alu_full),
    .empty (alu_empty)
  );

  cdb_fifo u_lsb_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (lsb_push),
    .data  ('{rob_id: bus.rob_id_from_lsb, result: bus.result_from_lsb}),
    .pop   (lsb_pop),
    .head  (lsb_head),
    .count (bus.lsb_count),
    .full  (lsb_full),
    .empty (lsb_empty)
  );

`ifdef CDB_RR_EN
  // Source preferred on the next contended grant; reset prefers the ALU.
  cdb_src_e rr_q, rr_d;

  always_comb begin
    rr_d = rr_q;
    if (grant_en && contended) rr_d = (rr_q == CDB_SRC_ALU) ? CDB_SRC_LSB : CDB_SRC_ALU;
  end

  always_ff @(posedge clk) begin
    if (rst) rr_q <= CDB_SRC_ALU;
    else     rr_q <= rr_d;
  end
`endif

  always_comb begin
    contended = !alu_empty && !lsb_empty;
    grant_en  = rdy && !flush && (!alu_empty || !lsb_empty);
    grant_src = CDB_SRC_ALU;
    if (contended) begin
`ifdef CDB_RR_EN
      grant_src = rr_q;
`else
      grant_src = CDB_SRC_LSB;
`endif
    end else if (!lsb_empty) begin
      grant_src = CDB_SRC_LSB;
    end
  end

  assign alu_pop = grant_en && (grant_src == CDB_SRC_ALU);
  assign lsb_pop = grant_en && (grant_src == CDB_SRC_LSB);

  always_comb begin
    cdb_valid_d  = 1'b0;
    cdb_rob_id_d = cdb_rob_id_q;
    cdb_result_d = cdb_result_q;
    cdb_src_d    = cdb_src_q;
    if (grant_en) begin
      cdb_valid_d  = 1'b1;
      cdb_src_d    = grant_src;
      cdb_rob_id_d = (grant_src == CDB_SRC_LSB) ? lsb_head.rob_id : alu_head.rob_id;
      cdb_result_d = (grant_src == CDB_SRC_LSB) ? lsb_head.result : alu_head.result;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_valid_q  <= 1'b0;
      cdb_rob_id_q <= ZERO_ROB;
      cdb_result_q <= '0;
      cdb_src_q    <= CDB_SRC_ALU;
    end else begin
      cdb_valid_q  <= cdb_valid_d;
      cdb_rob_id_q <= cdb_rob_id_d;
      cdb_result_q <= cdb_result_d;
      cdb_src_q    <= cdb_src_d;
    end
  end

  assign bus.cdb_valid  = cdb_valid_q;
  assign bus.cdb_rob_id = cdb_rob_id_q;
  assign bus.cdb_result = cdb_result_q;
  assign bus.cdb_src    = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus random traffic against a queue model.
// Expected ordering follows CDB_RR_EN when that macro is defined for the build.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int EW = ROB_ID_W + DATA_W;

  logic clk, rst, rdy;
  cdb_arbiter_if bus ();

  cdb_arbiter dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard / model state ----------------
  int checks = 0;
  int errors = 0;

  logic [EW-1:0] exp_alu_q[$];
  logic [EW-1:0] exp_lsb_q[$];
  logic          m_valid;
  logic [31:0]   m_rob, m_res;
  logic          m_src;
  logic          m_pref_lsb;
  logic          acc_alu, acc_lsb;
  int            seen_alu[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference behaviour for one clock edge, using the pre-edge request/ready values.
  task automatic model_edge(input logic ra, input logic rl);
    logic [EW-1:0] e;
    logic take_lsb;
    if (rst) begin
      exp_alu_q.delete();
      exp_lsb_q.delete();
      m_valid = 0; m_rob = 0; m_res = 0; m_src = 0; m_pref_lsb = 0;
    end else if (bus.commit_jump_flag_from_rob) begin
      exp_alu_q.delete();
      exp_lsb_q.delete();
      m_valid = 0;
    end else if (!rdy) begin
      m_valid = 0;
    end else begin
      if (exp_alu_q.size() > 0 && exp_lsb_q.size() > 0) begin
`ifdef CDB_RR_EN
        take_lsb   = m_pref_lsb;
        m_pref_lsb = !m_pref_lsb;
`else
        take_lsb = 1;
`endif
      end else begin
        take_lsb = (exp_lsb_q.size() > 0);
      end
      m_valid = (exp_alu_q.size() > 0 || exp_lsb_q.size() > 0);
      if (m_valid) begin
        e     = take_lsb ? exp_lsb_q.pop_front() : exp_alu_q.pop_front();
        m_rob = 32'(e[EW-1:DATA_W]);
        m_res = e[DATA_W-1:0];
        m_src = take_lsb;
      end
      if (bus.valid_from_alu && ra && bus.rob_id_from_alu != ZERO_ROB)
        exp_alu_q.push_back({bus.rob_id_from_alu, bus.result_from_alu});
      if (bus.valid_from_lsb && rl && bus.rob_id_from_lsb != ZERO_ROB)
        exp_lsb_q.push_back({bus.rob_id_from_lsb, bus.result_from_lsb});
    end
    acc_alu = bus.valid_from_alu && ra;
    acc_lsb = bus.valid_from_lsb && rl;
  endtask

  // One cycle: check readies, take the edge, update model, check registered outputs.
  task automatic step();
    logic ra, rl;
    ra = !rst && rdy && (exp_alu_q.size() < CDB_FIFO_DEPTH);
    rl = !rst && rdy && (exp_lsb_q.size() < CDB_FIFO_DEPTH);
    #2;
    check("ready_to_alu", 32'(bus.ready_to_alu), 32'(ra));
    check("ready_to_lsb", 32'(bus.ready_to_lsb), 32'(rl));
    @(posedge clk);
    model_edge(ra, rl);
    #1;
    check("cdb_valid", 32'(bus.cdb_valid), 32'(m_valid));
    check("cdb_rob_id", 32'(bus.cdb_rob_id), m_rob);
    check("cdb_result", bus.cdb_result, m_res);
    check("cdb_src", 32'(bus.cdb_src), 32'(m_src));
    check("alu_count", 32'(bus.alu_count), 32'(exp_alu_q.size()));
    check("lsb_count", 32'(bus.lsb_count), 32'(exp_lsb_q.size()));
    if (bus.cdb_valid && bus.cdb_src == CDB_SRC_ALU) seen_alu.push_back(int'(bus.cdb_rob_id));
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_alu(input logic v, input int id, input logic [31:0] r);
    bus.valid_from_alu  = v;
    bus.rob_id_from_alu = rob_id_t'(id);
    bus.result_from_alu = r;
  endtask

  task automatic set_lsb(input logic v, input int id, input logic [31:0] r);
    bus.valid_from_lsb  = v;
    bus.rob_id_from_lsb = rob_id_t'(id);
    bus.result_from_lsb = r;
  endtask

  task automatic idle();
    set_alu(0, 0, 0);
    set_lsb(0, 0, 0);
    bus.commit_jump_flag_from_rob = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    rdy = 1;
    idle();
    step();
    rst = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int alu_ids[3];
    int ai;
    logic pa, pl;
    int ida, idl;
    logic [31:0] rsa, rsl;

    rst = 1;
    rdy = 1;
    idle();

    // Reset values
    do_reset();
    check("rst_valid", 32'(bus.cdb_valid), 0);
    check("rst_rob_id", 32'(bus.cdb_rob_id), 0);
    check("rst_result", bus.cdb_result, 0);

    // Single ALU push, one-edge latency, single-cycle pulse
    set_alu(1, 3, 32'h11);
    step();
    idle();
    step();
    check("single_valid", 32'(bus.cdb_valid), 1);
    check("single_rob", 32'(bus.cdb_rob_id), 3);
    check("single_result", bus.cdb_result, 32'h11);
    check("single_src", 32'(bus.cdb_src), 0);
    step();
    check("single_pulse_end", 32'(bus.cdb_valid), 0);

    // Simultaneous ALU/LSB arrival
    do_reset();
    set_alu(1, 5, 32'hA);
    set_lsb(1, 6, 32'hB);
    step();
    idle();
    step();
`ifdef CDB_RR_EN
    check("contend_first", 32'(bus.cdb_rob_id), 5);
`else
    check("contend_first", 32'(bus.cdb_rob_id), 6);
`endif
    check("contend_first_v", 32'(bus.cdb_valid), 1);
    step();
`ifdef CDB_RR_EN
    check("contend_second", 32'(bus.cdb_rob_id), 6);
`else
    check("contend_second", 32'(bus.cdb_rob_id), 5);
`endif
    check("contend_second_v", 32'(bus.cdb_valid), 1);

    // Three ALU pushes against a saturated LSB, held until accepted
    do_reset();
    seen_alu.delete();
    alu_ids = '{7, 8, 9};
    ai = 0;
    for (int i = 0; i < 16; i++) begin
      if (i < 8) set_lsb(1, 10 + (i % 5), $urandom);
      else       set_lsb(0, 0, 0);
      if (ai < 3) set_alu(1, alu_ids[ai], 32'h100 + 32'(ai));
      else        set_alu(0, 0, 0);
      step();
      if (acc_alu) ai++;
    end
    idle();
    for (int i = 0; i < 4; i++) step();
    check("held_all_accepted", 32'(ai), 3);
    check("held_seen_count", 32'(seen_alu.size()), 3);
    for (int i = 0; i < 3; i++)
      if (i < seen_alu.size()) check("held_order", 32'(seen_alu[i]), 32'(alu_ids[i]));

    // Flush with both FIFOs loaded and a same-edge ALU push
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_alu(1, 1 + i, $urandom);
      set_lsb(1, 4 + i, $urandom);
      step();
    end
    set_alu(1, 7, 32'h77);
    set_lsb(0, 0, 0);
    bus.commit_jump_flag_from_rob = 1;
    step();
    idle();
    check("flush_valid", 32'(bus.cdb_valid), 0);
    check("flush_alu_count", 32'(bus.alu_count), 0);
    check("flush_lsb_count", 32'(bus.lsb_count), 0);
    check("flush_ready_alu", 32'(bus.ready_to_alu), 1);
    check("flush_ready_lsb", 32'(bus.ready_to_lsb), 1);
    for (int i = 0; i < 2; i++) begin
      step();
      check("flush_no_bcast", 32'(bus.cdb_valid), 0);
    end

    // ZERO_ROB request dropped
    do_reset();
    set_alu(1, 0, 32'h55);
    step();
    idle();
    check("zero_rob_count", 32'(bus.alu_count), 0);
    step();
    check("zero_rob_no_bcast", 32'(bus.cdb_valid), 0);

    // rdy low for 3 cycles with one entry pending
    set_alu(1, 9, 32'h99);
    step();
    idle();
    rdy = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("pause_no_bcast", 32'(bus.cdb_valid), 0);
      check("pause_count", 32'(bus.alu_count), 1);
    end
    rdy = 1;
    step();
    check("pause_resume_valid", 32'(bus.cdb_valid), 1);
    check("pause_resume_rob", 32'(bus.cdb_rob_id), 9);
    check("pause_resume_result", bus.cdb_result, 32'h99);

    // Random traffic; sources hold each request until the handshake completes
    do_reset();
    pa = 0; pl = 0; ida = 0; idl = 0; rsa = 0; rsl = 0;
    for (int c = 0; c < 500; c++) begin
      rdy = ($urandom_range(0, 9) != 0);
      rst = ($urandom_range(0, 99) == 0);
      bus.commit_jump_flag_from_rob = ($urandom_range(0, 29) == 0);
      if (!pa && $urandom_range(0, 2) != 0) begin
        pa = 1; ida = $urandom_range(0, 15); rsa = $urandom;
      end
      if (!pl && $urandom_range(0, 2) != 0) begin
        pl = 1; idl = $urandom_range(0, 15); rsl = $urandom;
      end
      set_alu(pa, ida, rsa);
      set_lsb(pl, idl, rsl);
      step();
      if (acc_alu) pa = 0;
      if (acc_lsb) pl = 0;
    end

    rst = 0;
    rdy = 1;
    idle();
    for (int i = 0; i < 6; i++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
